colparity_ctrl: RTL and testbench

Sequencer and datapath for the column-parity pass over a 5×5×64 bit state. It fetches one 25-bit slice per z index from upstream slice storage and reduces each slice to a 5-bit column parity word for the downstream parity buffer. The z index comes from the external 6-bit index counter, which this block drives through `cnt_clr` and `cnt_en` and monitors through its value and carry-out.

---
 rtl/colparity_ctrl.sv | 151 +++++++++++++++
 tb/tb_colparity_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/colparity_ctrl.sv
// Column-parity sequencer: walks z = 0..63 through an external index counter and
// reduces each 25-bit slice to a 5-bit column parity word. Option: COLPARITY_CHKSUM_EN.
module colparity_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        slice_req,
    input  logic [24:0] slice_in,
    input  logic        slice_valid,
    input  logic [5:0]  cnt_val,
    input  logic        cnt_co,
    output logic        cnt_clr,
    output logic        cnt_en,
    output logic [4:0]  parity_out,
    output logic [5:0]  parity_z,
    output logic        parity_wr,
    output logic        busy,
`ifdef COLPARITY_CHKSUM_EN
    output logic [4:0]  chksum,
`endif
    output logic        done
);

    localparam int unsigned SLICES  = 64;
    localparam int unsigned W_IDX   = $clog2(SLICES);
    localparam int unsigned W_COL   = 5;
    localparam int unsigned W_SLICE = W_COL * W_COL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_REQ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               r_state;
    logic                 r_slice_req;
    logic                 r_cnt_clr;
    logic                 r_cnt_en;
    logic                 r_parity_wr;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_last;
    logic [W_COL-1:0]     r_parity_out;
    logic [W_IDX-1:0]     r_parity_z;
    logic [W_COL-1:0]     w_col;
    logic [W_SLICE-1:0]   w_slice;
`ifdef COLPARITY_CHKSUM_EN
    logic [W_COL-1:0]     r_chksum;
`endif

    assign w_slice = slice_in;

    // C[x] = XOR over rows y of bit 5*y+x
    always_comb begin
        w_col = '0;
        for (int y = 0; y < W_COL; y++) begin
            for (int x = 0; x < W_COL; x++) begin
                w_col[x] = w_col[x] ^ w_slice[W_COL*y + x];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_slice_req  <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_cnt_en     <= 1'b0;
            r_parity_wr  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_last       <= 1'b0;
            r_parity_out <= '0;
            r_parity_z   <= '0;
`ifdef COLPARITY_CHKSUM_EN
            r_chksum     <= '0;
`endif
        end else begin
            r_cnt_clr   <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_parity_wr <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_CLR;
                        r_cnt_clr <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_parity_out <= '0;
                    r_parity_z   <= '0;
`ifdef COLPARITY_CHKSUM_EN
                    r_chksum     <= '0;
`endif
                    r_slice_req  <= 1'b1;
                    r_state      <= S_REQ;
                end
                S_REQ: begin
                    if (slice_valid) begin
                        r_parity_out <= w_col;
                        r_parity_z   <= W_IDX'(cnt_val);
                        r_last       <= cnt_co;
                        r_slice_req  <= 1'b0;
                        r_parity_wr  <= 1'b1;
                        // Increment lands during WRITE so the next REQ sees the new index
                        r_cnt_en     <= ~cnt_co;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
`ifdef COLPARITY_CHKSUM_EN
                    r_chksum <= r_chksum ^ r_parity_out;
`endif
                    if (r_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_slice_req <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_slice_req <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign slice_req  = r_slice_req;
    assign cnt_clr    = r_cnt_clr;
    assign cnt_en     = r_cnt_en;
    assign parity_out = r_parity_out;
    assign parity_z   = r_parity_z;
    assign parity_wr  = r_parity_wr;
    assign busy       = r_busy;
    assign done       = r_done;
`ifdef COLPARITY_CHKSUM_EN
    assign chksum     = r_chksum;
`endif

endmodule

// File: tb/tb_colparity_ctrl.sv
// Directed bench for colparity_ctrl with a behavioural 6-bit index counter and a
// slice responder of configurable latency.
module tb_colparity_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        slice_req;
    logic [24:0] slice_in;
    logic        slice_valid;
    logic [5:0]  cnt_val;
    logic        cnt_co;
    logic        cnt_clr;
    logic        cnt_en;
    logic [4:0]  parity_out;
    logic [5:0]  parity_z;
    logic        parity_wr;
    logic        busy;
    logic        done;
`ifdef COLPARITY_CHKSUM_EN
    logic [4:0]  chksum;
    logic [4:0]  s_chk;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0]  cnt = 6'd42;
    logic [24:0] pat = '0;
    logic [24:0] pat_last = '0;
    int          wait_cyc = 0;
    int          wcnt = 0;
    bit          tie_valid = 1'b0;
    bit          resp_en = 1'b0;
    bit          force_valid = 1'b0;
    logic        resp_valid = 1'b0;

    int s_wr, s_bad_par, s_bad_z, s_done_cyc, s_clr, s_en_clr, s_en_req;
    int s_req_min, s_req_max, s_first_req;

    always #5 clk = ~clk;

    colparity_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .slice_req  (slice_req),
        .slice_in   (slice_in),
        .slice_valid(slice_valid),
        .cnt_val    (cnt_val),
        .cnt_co     (cnt_co),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .parity_out (parity_out),
        .parity_z   (parity_z),
        .parity_wr  (parity_wr),
        .busy       (busy),
`ifdef COLPARITY_CHKSUM_EN
        .chksum     (chksum),
`endif
        .done       (done)
    );

    // External index counter
    always @(posedge clk) begin
        if (cnt_clr)     cnt <= 6'd0;
        else if (cnt_en) cnt <= cnt + 6'd1;
    end
    assign cnt_val     = cnt;
    assign cnt_co      = (cnt == 6'd63);
    assign slice_in    = (cnt == 6'd63) ? pat_last : pat;
    assign slice_valid = resp_valid | force_valid;

    // Slice storage: answers a request after wait_cyc idle cycles
    always @(negedge clk) begin
        if (tie_valid) resp_valid = 1'b1;
        else if (!resp_en) begin resp_valid = 1'b0; wcnt = 0; end
        else if (resp_valid) begin resp_valid = 1'b0; wcnt = 0; end
        else if (slice_req) begin
            if (wcnt == wait_cyc) resp_valid = 1'b1;
            else wcnt++;
        end else wcnt = 0;
    end

    task automatic run_pass(input logic [24:0] p, input logic [24:0] pl,
                            input logic [4:0] e, input logic [4:0] el,
                            input int w, input bit tie, input int start_at);
        int run;
        int exp_z;
        bit fin;
        logic [4:0] ep;
        pat = p; pat_last = pl; wait_cyc = w; tie_valid = tie; resp_en = 1'b1;
        s_wr = 0; s_bad_par = 0; s_bad_z = 0; s_done_cyc = -1; s_clr = 0;
        s_en_clr = 0; s_en_req = 0; s_req_min = 1000; s_req_max = 0; s_first_req = -1;
        run = 0; exp_z = 0; fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 2000 && !fin; cyc++) begin
            @(negedge clk);
            start = (cyc == start_at);
            if (cnt_clr) s_clr++;
            if (cnt_clr && cnt_en) s_en_clr++;
            if (cnt_en && slice_req) s_en_req++;
            if (slice_req) begin
                run++;
                if (s_first_req < 0) s_first_req = cyc;
            end else if (run > 0) begin
                if (run < s_req_min) s_req_min = run;
                if (run > s_req_max) s_req_max = run;
                run = 0;
            end
            if (parity_wr) begin
                ep = (exp_z == 63) ? el : e;
                if (parity_out !== ep) s_bad_par++;
                if (parity_z !== 6'(exp_z)) s_bad_z++;
                exp_z++;
                s_wr++;
            end
            if (done === 1'b1) begin
                s_done_cyc = cyc;
                fin = 1'b1;
`ifdef COLPARITY_CHKSUM_EN
                s_chk = chksum;
`endif
            end
        end
        start = 1'b0; tie_valid = 1'b0; resp_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({slice_req, cnt_clr, cnt_en, parity_wr, busy, done} !== 6'b0) begin
            n_err++; $display("FAIL reset_strobes: got %b want 000000",
                              {slice_req, cnt_clr, cnt_en, parity_wr, busy, done});
        end
        n_cmp++;
        if ({parity_out, parity_z} !== 11'b0) begin
            n_err++; $display("FAIL reset_data: got %h/%h want 0/0", parity_out, parity_z);
        end
`ifdef COLPARITY_CHKSUM_EN
        n_cmp++;
        if (chksum !== 5'b0) begin n_err++; $display("FAIL reset_chksum: got %b want 0", chksum); end
`endif
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        run_pass(25'h1FFFFFF, 25'h1FFFFFF, 5'b11111, 5'b11111, 0, 1'b1, 0);
        n_cmp++; if (s_wr !== 64) begin n_err++; $display("FAIL ones_wr_count: got %0d want 64", s_wr); end
        n_cmp++; if (s_bad_par !== 0) begin n_err++; $display("FAIL ones_parity: got %0d bad want 0", s_bad_par); end
        n_cmp++; if (s_bad_z !== 0) begin n_err++; $display("FAIL ones_z_seq: got %0d bad want 0", s_bad_z); end
        n_cmp++; if (s_done_cyc !== 130) begin n_err++; $display("FAIL ones_done_cycle: got %0d want 130", s_done_cyc); end
        n_cmp++; if (s_first_req !== 2) begin n_err++; $display("FAIL ones_first_req: got %0d want 2", s_first_req); end
        n_cmp++; if (s_clr !== 1) begin n_err++; $display("FAIL ones_clr_count: got %0d want 1", s_clr); end
        n_cmp++; if (s_en_clr !== 0) begin n_err++; $display("FAIL ones_en_clr_overlap: got %0d want 0", s_en_clr); end
`ifdef COLPARITY_CHKSUM_EN
        n_cmp++; if (s_chk !== 5'b0) begin n_err++; $display("FAIL ones_chksum: got %b want 00000", s_chk); end
`endif
        repeat (3) @(negedge clk);
        n_cmp++; if (parity_z !== 6'd63) begin n_err++; $display("FAIL ones_z_hold: got %0d want 63", parity_z); end
        n_cmp++; if (parity_out !== 5'b11111) begin n_err++; $display("FAIL ones_par_hold: got %b want 11111", parity_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ones_busy_after: got %b want 0", busy); end
        n_cmp++; if (cnt_val !== 6'd63) begin n_err++; $display("FAIL ones_cnt_stays: got %0d want 63", cnt_val); end
    endtask

    task automatic test_patterns();
        run_pass(25'h0000001, 25'h0000001, 5'b00001, 5'b00001, 0, 1'b0, 0);
        n_cmp++; if (s_bad_par !== 0 || s_wr !== 64) begin n_err++; $display("FAIL bit0_parity: got %0d bad of %0d want 0 of 64", s_bad_par, s_wr); end
        n_cmp++; if (s_done_cyc !== 130) begin n_err++; $display("FAIL bit0_done_cycle: got %0d want 130", s_done_cyc); end
        // bits 0,1,2 (y=0) and 6,7 (y=1, x=1,2): x1 and x2 cancel
        run_pass(25'h00000C7, 25'h00000C7, 5'b00001, 5'b00001, 0, 1'b0, 0);
        n_cmp++; if (s_bad_par !== 0 || s_wr !== 64) begin n_err++; $display("FAIL c7_parity: got %0d bad of %0d want 0 of 64", s_bad_par, s_wr); end
        // bit1 -> x1, bit5 -> x0; last slice all ones
        run_pass(25'h0000022, 25'h1FFFFFF, 5'b00011, 5'b11111, 0, 1'b0, 0);
        n_cmp++; if (s_bad_par !== 0 || s_wr !== 64) begin n_err++; $display("FAIL mixed_parity: got %0d bad of %0d want 0 of 64", s_bad_par, s_wr); end
`ifdef COLPARITY_CHKSUM_EN
        n_cmp++; if (s_chk !== 5'b11100) begin n_err++; $display("FAIL mixed_chksum: got %b want 11100", s_chk); end
`endif
    endtask

    task automatic test_wait_and_start();
        run_pass(25'h1084210, 25'h1084210, 5'b10000, 5'b10000, 3, 1'b0, 10);
        n_cmp++; if (s_done_cyc !== 322) begin n_err++; $display("FAIL wait_done_cycle: got %0d want 322", s_done_cyc); end
        n_cmp++; if (s_req_min !== 4 || s_req_max !== 4) begin n_err++; $display("FAIL wait_req_len: got %0d..%0d want 4..4", s_req_min, s_req_max); end
        n_cmp++; if (s_en_req !== 0) begin n_err++; $display("FAIL wait_en_in_req: got %0d want 0", s_en_req); end
        n_cmp++; if (s_clr !== 1) begin n_err++; $display("FAIL start_ignored_clr: got %0d want 1", s_clr); end
        n_cmp++; if (s_wr !== 64 || s_bad_z !== 0 || s_bad_par !== 0) begin
            n_err++; $display("FAIL wait_writes: got %0d wr %0d badz %0d badp want 64 0 0", s_wr, s_bad_z, s_bad_par);
        end
    endtask

    task automatic test_idle_valid();
        int hits;
        hits = 0;
        force_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (parity_wr || slice_req || busy) hits++;
        end
        force_valid = 1'b0;
        n_cmp++; if (hits !== 0) begin n_err++; $display("FAIL idle_valid_ignored: got %0d active cycles want 0", hits); end
    endtask

    task automatic test_reset_midpass();
        bit found;
        found = 1'b0;
        pat = 25'h0000001; pat_last = 25'h0000001; wait_cyc = 3; resp_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (slice_req === 1'b1 && cnt_val == 6'd17) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL midpass_reach_z17: got timeout want REQ at z=17"); end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({slice_req, cnt_clr, cnt_en, parity_wr, busy, done, parity_out, parity_z} !== 17'b0) begin
            n_err++; $display("FAIL midpass_async_clear: got %b want all 0",
                {slice_req, cnt_clr, cnt_en, parity_wr, busy, done, parity_out, parity_z});
        end
        resp_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (cnt_val !== 6'd17) begin n_err++; $display("FAIL midpass_cnt_frozen: got %0d want 17", cnt_val); end
        run_pass(25'h0000001, 25'h0000001, 5'b00001, 5'b00001, 0, 1'b0, 0);
        n_cmp++; if (s_clr !== 1) begin n_err++; $display("FAIL restart_clr: got %0d want 1", s_clr); end
        n_cmp++; if (s_wr !== 64 || s_bad_z !== 0) begin n_err++; $display("FAIL restart_z_seq: got %0d wr %0d badz want 64 0", s_wr, s_bad_z); end
        n_cmp++; if (s_done_cyc !== 130) begin n_err++; $display("FAIL restart_done_cycle: got %0d want 130", s_done_cyc); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_wait_and_start();
        test_idle_valid();
        test_reset_midpass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
